// File: rtl/wb_sram_responder.sv
// Wishbone stb/nak responder for the external 48-bit asynchronous SRAM.
// Each accepted request runs one fixed-length SRAM cycle: SETUP, ACCESS x WAIT, DONE.
module wb_sram_responder #(
   parameter int ADDR_BITS  = 20,
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_stb,
   input  logic [31:0]          wb_addr,
   input  logic [3:0]           wb_we,
   input  logic [31:0]          wb_din,
   output logic [47:0]          wb_dout,
   output logic                 wb_nak,
   output logic [ADDR_BITS-1:0] sram_addr,
   input  logic [47:0]          sram_dq_i,
   output logic [47:0]          sram_dq_o,
   output logic                 sram_dq_oe,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output logic [5:0]           sram_be_n
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   typedef struct packed {
      logic       wr;
      logic [3:0] be;
   } req_t;

   localparam logic [3:0] RD_CNT = 4'(READ_WAIT);
   localparam logic [3:0] WR_CNT = 4'(WRITE_WAIT);

   state_t     state;
   req_t       req;
   logic [3:0] cnt;

   // Address bits above ADDR_BITS wrap silently.
   logic unused_addr_hi;
   assign unused_addr_hi = ^wb_addr[31:ADDR_BITS];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req        <= '0;
         cnt        <= '0;
         wb_nak     <= 1'b0;
         wb_dout    <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_be_n  <= 6'h3F;
      end else begin
         case (state)
            IDLE: begin
               wb_nak     <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               sram_be_n  <= 6'h3F;
               if (wb_stb) begin
                  req.wr    <= |wb_we;
                  req.be    <= wb_we;
                  sram_addr <= wb_addr[ADDR_BITS-1:0];
                  wb_nak    <= 1'b1;
                  sram_ce_n <= 1'b0;
                  if (|wb_we) begin
                     sram_dq_o  <= {16'h0, wb_din};
                     sram_dq_oe <= 1'b1;
                     sram_be_n  <= {2'b11, ~wb_we};
                  end else begin
                     sram_oe_n <= 1'b0;
                     sram_be_n <= 6'h00;
                  end
                  state <= SETUP;
               end
            end

            SETUP: begin
               if (req.wr) begin
                  cnt       <= WR_CNT;
                  sram_we_n <= 1'b0;
                  state     <= ACCESS;
               end else if (RD_CNT == 4'd0) begin
                  // Zero-wait read: SETUP is the sampling cycle.
                  wb_dout   <= sram_dq_i;
                  wb_nak    <= 1'b0;
                  sram_oe_n <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt   <= RD_CNT;
                  state <= ACCESS;
               end
            end

            ACCESS: begin
               if (cnt <= 4'd1) begin
                  if (!req.wr)
                     wb_dout <= sram_dq_i;
                  cnt       <= '0;
                  wb_nak    <= 1'b0;
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            DONE: begin
               // Write data was held through DONE; release everything now.
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               sram_be_n  <= 6'h3F;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Random + directed bench for wb_sram_responder; two instances (READ_WAIT 2 and 0)
// checked every cycle against a phase-by-cycle-offset model of each request.
module tb_wb_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_stb;
   logic [31:0] wb_addr;
   logic [3:0]  wb_we;
   logic [31:0] wb_din;
   logic [47:0] sram_dq_i;

   logic [47:0] dout  [2];
   logic        nak   [2];
   logic [19:0] saddr [2];
   logic [47:0] dqo   [2];
   logic        dqoe  [2];
   logic        ce_n  [2];
   logic        oe_n  [2];
   logic        we_n  [2];
   logic [5:0]  be_n  [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_sram_responder #(.ADDR_BITS(20), .READ_WAIT(2), .WRITE_WAIT(2)) u0 (
      .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_addr(wb_addr), .wb_we(wb_we),
      .wb_din(wb_din), .wb_dout(dout[0]), .wb_nak(nak[0]), .sram_addr(saddr[0]),
      .sram_dq_i(sram_dq_i), .sram_dq_o(dqo[0]), .sram_dq_oe(dqoe[0]),
      .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0]));

   wb_sram_responder #(.ADDR_BITS(20), .READ_WAIT(0), .WRITE_WAIT(3)) u1 (
      .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_addr(wb_addr), .wb_we(wb_we),
      .wb_din(wb_din), .wb_dout(dout[1]), .wb_nak(nak[1]), .sram_addr(saddr[1]),
      .sram_dq_i(sram_dq_i), .sram_dq_o(dqo[1]), .sram_dq_oe(dqoe[1]),
      .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1]));

   function automatic int wait_of(int i, bit wr);
      if (i == 0) return 2;
      return wr ? 3 : 0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: each request is described by its acceptance cycle; phase is the offset from it.
   int          cyc = 0;
   bit          started = 1'b0;
   int          t0   [2] = '{-100, -100};
   bit          mwr  [2];
   logic [19:0] maddr[2];
   logic [3:0]  mwe  [2];
   logic [31:0] mdin [2];
   logic [47:0] mdout[2];

   always @(posedge clk) begin : model
      int k, w;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            t0[i] = -100;
            mdout[i] = '0;
         end else begin
            k = cyc - t0[i];
            w = wait_of(i, mwr[i]);
            if (!mwr[i] && k == w + 1) mdout[i] = sram_dq_i;
            if (!(k >= 1 && k <= w + 2) && wb_stb) begin
               t0[i] = cyc;
               mwr[i] = |wb_we;
               maddr[i] = wb_addr[19:0];
               mwe[i] = wb_we;
               mdin[i] = wb_din;
            end
         end
      end
      if (rst) started = 1'b1;
      cyc++;
   end

   always @(negedge clk) begin : compare
      int k, w, ph;
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            k = cyc - t0[i];
            w = wait_of(i, mwr[i]);
            if (k == 1) ph = 1;
            else if (k >= 2 && k <= w + 1) ph = 2;
            else if (k == w + 2) ph = 3;
            else ph = 0;
            chk($sformatf("nak%0d", i), nak[i], (ph == 1 || ph == 2));
            chk($sformatf("ce_n%0d", i), ce_n[i], (ph == 0));
            chk($sformatf("oe_n%0d", i), oe_n[i], !((ph == 1 || ph == 2) && !mwr[i]));
            chk($sformatf("we_n%0d", i), we_n[i], !(ph == 2 && mwr[i]));
            chk($sformatf("dq_oe%0d", i), dqoe[i], (ph != 0 && mwr[i]));
            chk($sformatf("be_n%0d", i), be_n[i],
                (ph == 0) ? 6'h3F : (mwr[i] ? {2'b11, ~mwe[i]} : 6'h00));
            chk($sformatf("dout%0d", i), dout[i], mdout[i]);
            if (ph != 0) chk($sformatf("addr%0d", i), saddr[i], maddr[i]);
            if (ph != 0 && mwr[i]) chk($sformatf("dq_o%0d", i), dqo[i], {16'h0, mdin[i]});
         end
      end
   end

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   task automatic req(logic [31:0] a, logic [3:0] we, logic [31:0] d);
      wb_stb = 1'b1; wb_addr = a; wb_we = we; wb_din = d;
   endtask

   task automatic idle_cycles(int n);
      wb_stb = 1'b0;
      repeat (n) adv();
   endtask

   initial begin
      logic [63:0] r64;
      rst = 1'b1; wb_stb = 1'b0; wb_addr = '0; wb_we = '0; wb_din = '0; sram_dq_i = '0;
      // Reset held 3 cycles with random inputs, including stb.
      repeat (3) begin
         adv();
         wb_stb = 1'b1; wb_addr = $urandom; wb_we = 4'($urandom); wb_din = $urandom;
         r64 = {$urandom, $urandom}; sram_dq_i = r64[47:0];
      end
      rst = 1'b0; wb_stb = 1'b0; wb_we = '0;
      chk("rst_nak", nak[0], 1'b0);
      chk("rst_dout", dout[0], 48'h0);
      chk("rst_addr", saddr[0], 20'h0);
      chk("rst_dqo", dqo[0], 48'h0);
      chk("rst_ce_we_oe_dqoe", {ce_n[0], we_n[0], oe_n[0], dqoe[0]}, 4'b1110);
      chk("rst_be", be_n[0], 6'h3F);
      idle_cycles(2);

      // Read, 2 wait cycles.
      sram_dq_i = 48'hABCD_0123_4567;
      req(32'h0001_2345, 4'b0000, 32'h0);
      adv(); wb_stb = 1'b0;
      chk("rd_addr_c1", saddr[0], 20'h12345);
      chk("rd_oe_c1", oe_n[0], 1'b0);
      chk("rd_nak_c1", nak[0], 1'b1);
      adv(); chk("rd_nak_c2", {nak[0], oe_n[0]}, 2'b10);
      adv(); chk("rd_nak_c3", {nak[0], oe_n[0]}, 2'b10);
      adv();
      chk("rd_nak_c4", nak[0], 1'b0);
      chk("rd_dout_c4", dout[0], 48'hABCD_0123_4567);
      chk("rd0_dout_c4", dout[1], 48'hABCD_0123_4567);
      idle_cycles(4);

      // Write, byte lanes 2 and 0.
      sram_dq_i = 48'h5555_5555_5555;
      req(32'h0000_0010, 4'b0101, 32'hDEAD_BEEF);
      adv(); wb_stb = 1'b0;
      chk("wr_be_c1", be_n[0], 6'b111010);
      chk("wr_dqo_c1", dqo[0], 48'h0000_DEAD_BEEF);
      chk("wr_we_c1", we_n[0], 1'b1);
      adv(); chk("wr_we_c2", we_n[0], 1'b0);
      adv(); chk("wr_we_c3", we_n[0], 1'b0);
      adv();
      chk("wr_nak_c4", {nak[0], we_n[0], ce_n[0], dqoe[0]}, 4'b0101);
      chk("wr_dout_c4", dout[0], 48'hABCD_0123_4567);
      adv(); chk("wr_rel_c5", {ce_n[0], dqoe[0], be_n[0]}, {1'b1, 1'b0, 6'h3F});
      idle_cycles(4);

      // Back-to-back reads, stray stb in cycle 2.
      req(32'h0000_0AAA, 4'b0, 32'h0);
      adv(); wb_stb = 1'b0;
      adv(); req(32'h0000_0BBB, 4'b0, 32'h0);
      adv(); wb_stb = 1'b0;
      chk("b2b_addr_c3", saddr[0], 20'h00AAA);
      adv();
      adv(); req(32'h0000_0CCC, 4'b0, 32'h0);
      chk("b2b_idle_c5", {ce_n[0], nak[0]}, 2'b10);
      adv(); wb_stb = 1'b0;
      chk("b2b_acc_c6", {saddr[0], nak[0]}, {20'h00CCC, 1'b1});
      idle_cycles(6);

      // Reset during ACCESS of a write.
      req(32'h0000_0055, 4'b1111, 32'h1234_5678);
      adv(); wb_stb = 1'b0;
      adv(); rst = 1'b1;
      chk("abort_we_c2", we_n[0], 1'b0);
      adv(); rst = 1'b0;
      chk("abort_c3", {we_n[0], ce_n[0], dqoe[0], nak[0]}, 4'b1100);
      idle_cycles(4);

      // Zero-wait read with address wrap.
      sram_dq_i = 48'h1111_2222_3333;
      req(32'h0010_0003, 4'b0, 32'h0);
      adv(); wb_stb = 1'b0;
      chk("rw0_addr_c1", saddr[1], 20'h00003);
      chk("rw0_nak_c1", nak[1], 1'b1);
      chk("wrap_addr_c1", saddr[0], 20'h00003);
      adv();
      chk("rw0_nak_c2", nak[1], 1'b0);
      chk("rw0_dout_c2", dout[1], 48'h1111_2222_3333);
      idle_cycles(5);

      // Random traffic, occasional reset.
      for (int n = 0; n < 3000; n++) begin
         wb_stb = ($urandom % 3) == 0;
         wb_addr = $urandom;
         wb_we = ($urandom % 2) ? 4'($urandom) : 4'h0;
         wb_din = $urandom;
         r64 = {$urandom, $urandom};
         sram_dq_i = r64[47:0];
         rst = ($urandom % 300) == 0;
         adv();
      end
      rst = 1'b0;
      idle_cycles(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
